pc_deco: RTL and testbench
==========================

# pc_deco

Next-PC source decoder for the processor control path. Combines the branch type, jump type and the ALU comparison flags of the instruction in decode into a 2-bit select that steers the PC input mux (sequential, branch target, absolute jump, register jump). The select is registered so the fetch stage sees a stable value at the next clock edge. Also flags pipeline flushes and illegal jump encodings, with optional per-event counters.

## Interface
Parameters:
- CNT_W, default 16: width of the statistics counters (only used with PC_DECO_STATS_EN).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- BranchSel  in  2  branch type: 00 none, 01 branch-if-equal, 10 branch-if-greater, 11 branch-if-not-equal.
- eq  in  1  comparison result: operands equal.
- bgt  in  1  comparison result: first operand greater than second.
- JMPSel  in  2  jump type: 00 none, 01 absolute/immediate jump, 10 register jump, 11 reserved.
- stall  in  1  pipeline stall; when high, all registers hold.
- NextInstrSel  out  2  PC mux select: 00 PC+1, 01 branch target, 10 absolute jump target, 11 register jump target.
- flush  out  1  high when the registered NextInstrSel is not 00, i.e. a redirect happened and younger instructions must be squashed.
- illegal_jmp  out  1  registered flag: JMPSel was 11 in the sampled cycle.
- With PC_DECO_STATS_EN only: branch_cnt, taken_cnt, jump_cnt  out  CNT_W each  event counters.

## Operation
- Next-value decode, priority order:
  - JMPSel 01 -> 10.
  - JMPSel 10 -> 11.
  - JMPSel 11 -> 00, illegal_jmp next = 1; any branch in the same cycle is ignored.
  - JMPSel 00:
    - BranchSel 01 -> 01 if eq, else 00.
    - BranchSel 10 -> 01 if bgt, else 00.
    - BranchSel 11 -> 01 if !eq, else 00.
    - BranchSel 00 -> 00.
- Jumps override branches unconditionally; eq and bgt are don't-cares when JMPSel != 00.
- flush next = (decoded select != 00).
- illegal_jmp next = (JMPSel == 11); it is not sticky.
- eq and bgt are independent inputs; eq=1 with bgt=1 is accepted without error, and each branch type reads only its own flag.

## Timing
- Rising edge with rst=1: NextInstrSel=00, flush=0, illegal_jmp=0, all counters 0. rst overrides stall.
- Rising edge with rst=0, stall=0: NextInstrSel, flush and illegal_jmp load their decoded next values. Latency is exactly one cycle from input to output.
- Rising edge with rst=0, stall=1: all outputs and counters hold; inputs are ignored.
- Reset asserted mid-redirect: outputs return to 00/0 at that edge, and the redirect is lost.
- No handshake; inputs are sampled every non-stalled cycle.
- Outputs are driven directly from flops and have no combinational path from inputs.

## Configuration
- Macro PC_DECO_STATS_EN.
  - Defined: three CNT_W-bit saturating counters, updated on non-stalled, non-reset edges.
    - branch_cnt increments when JMPSel==00 and BranchSel!=00.
    - taken_cnt increments when such a branch resolves to 01.
    - jump_cnt increments when JMPSel is 01 or 10.
    - Each counter holds at all-ones and clears on rst.
  - Not defined: the counter ports and logic do not exist, and the remaining behaviour is identical.

## Test plan
- Reset: rst=1 for 2 cycles with JMPSel=01 -> NextInstrSel=00, flush=0, illegal_jmp=0; first edge after release -> NextInstrSel=10.
- Jumps: eq=1, bgt=1, BranchSel=00; JMPSel 00 -> 01 -> 10 on successive cycles -> NextInstrSel 00, 10, 11 one cycle later each; flush 0, 1, 1.
- Branches: JMPSel=00, eq=1, bgt=1; BranchSel=01 -> 01; BranchSel=10 -> 01; then bgt=0 -> 00; BranchSel=11 with eq=1 -> 00, with eq=0 -> 01.
- Priority and illegal: JMPSel=10 with BranchSel=01, eq=1 -> 11; JMPSel=11 with BranchSel=01, eq=1 -> NextInstrSel=00, illegal_jmp=1, flush=0.
- Stall: load 10, then stall=1 while JMPSel=00 for 3 cycles -> NextInstrSel stays 10; release -> 00.
- Stats (PC_DECO_STATS_EN, CNT_W=2): 5 taken BranchSel=01 branches -> branch_cnt=3, taken_cnt=3 (saturated); 1 jump -> jump_cnt=1; rst -> all 0.

Source files
------------

// File: rtl/pc_deco_if.sv
// pc_deco_if: decode-stage inputs and registered PC-select outputs of the
// next-PC source decoder. The master side is the control path that drives
// the decode inputs. The slave side is the decoder itself.
interface pc_deco_if;
    logic [1:0] BranchSel;
    logic       eq;
    logic       bgt;
    logic [1:0] JMPSel;
    logic       stall;
    logic [1:0] NextInstrSel;
    logic       flush;
    logic       illegal_jmp;

    modport master (
        output BranchSel, eq, bgt, JMPSel, stall,
        input  NextInstrSel, flush, illegal_jmp
    );

    modport slave (
        input  BranchSel, eq, bgt, JMPSel, stall,
        output NextInstrSel, flush, illegal_jmp
    );
endinterface

// File: rtl/pc_deco.sv
// pc_deco: next-PC source decoder.
// Combines the jump type, the branch type and the comparison flags into the
// 2-bit PC mux select:
//   00 = PC+1, 01 = branch target, 10 = absolute jump, 11 = register jump.
// The select, the flush flag and the illegal-jump flag are registered, so
// the outputs come straight from flops one cycle after the inputs.
// A high stall freezes every register. rst is synchronous and takes
// priority over stall.
// Optional macro PC_DECO_STATS_EN adds three saturating CNT_W-bit event
// counters: branch_cnt, taken_cnt and jump_cnt.
module pc_deco #(
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    pc_deco_if.slave      bus
`ifdef PC_DECO_STATS_EN
    ,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] jump_cnt
`endif
);

    localparam logic [1:0] SEL_SEQ    = 2'b00;
    localparam logic [1:0] SEL_BRANCH = 2'b01;
    localparam logic [1:0] SEL_JABS   = 2'b10;
    localparam logic [1:0] SEL_JREG   = 2'b11;

    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_ABS  = 2'b01;
    localparam logic [1:0] JMP_REG  = 2'b10;
    localparam logic [1:0] JMP_RSVD = 2'b11;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_EQ   = 2'b01;
    localparam logic [1:0] BR_GT   = 2'b10;
    localparam logic [1:0] BR_NE   = 2'b11;

    // A zero-width counter would make no sense, even when the stats are disabled.
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("pc_deco: CNT_W must be at least 1");
    end

    logic [1:0] sel_next;
    logic       illegal_next;
    logic       branch_taken;

    logic [1:0] sel_q;
    logic       flush_q;
    logic       illegal_q;

    // Branch condition: each branch type looks only at its own flag.
    always_comb begin
        branch_taken = 1'b0;
        unique case (bus.BranchSel)
            BR_EQ:   branch_taken = bus.eq;
            BR_GT:   branch_taken = bus.bgt;
            BR_NE:   branch_taken = !bus.eq;
            BR_NONE: branch_taken = 1'b0;
            default: branch_taken = 1'b0;
        endcase
    end

    // Next-select decode. Jumps beat branches, and a reserved jump suppresses both.
    always_comb begin
        sel_next     = SEL_SEQ;
        illegal_next = 1'b0;
        unique case (bus.JMPSel)
            JMP_ABS:  sel_next = SEL_JABS;
            JMP_REG:  sel_next = SEL_JREG;
            JMP_RSVD: begin
                sel_next     = SEL_SEQ;
                illegal_next = 1'b1;
            end
            JMP_NONE: sel_next = branch_taken ? SEL_BRANCH : SEL_SEQ;
            default:  sel_next = SEL_SEQ;
        endcase
    end

    // Output registers: clear on reset, hold on stall, otherwise load the decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q     <= SEL_SEQ;
            flush_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else if (!bus.stall) begin
            sel_q     <= sel_next;
            flush_q   <= (sel_next != SEL_SEQ);
            illegal_q <= illegal_next;
        end
    end

    assign bus.NextInstrSel = sel_q;
    assign bus.flush        = flush_q;
    assign bus.illegal_jmp  = illegal_q;

`ifdef PC_DECO_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic branch_ev;
    logic taken_ev;
    logic jump_ev;

    // Event qualifiers. A reserved jump counts as neither a branch nor a jump.
    always_comb begin
        branch_ev = (bus.JMPSel == JMP_NONE) && (bus.BranchSel != BR_NONE);
        taken_ev  = branch_ev && (sel_next == SEL_BRANCH);
        jump_ev   = (bus.JMPSel == JMP_ABS) || (bus.JMPSel == JMP_REG);
    end

    // Saturating event counters that follow the same reset and stall rules as the select.
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt <= '0;
            taken_cnt  <= '0;
            jump_cnt   <= '0;
        end else if (!bus.stall) begin
            if (branch_ev && (branch_cnt != CNT_MAX)) branch_cnt <= branch_cnt + CNT_ONE;
            if (taken_ev  && (taken_cnt  != CNT_MAX)) taken_cnt  <= taken_cnt  + CNT_ONE;
            if (jump_ev   && (jump_cnt   != CNT_MAX)) jump_cnt   <= jump_cnt   + CNT_ONE;
        end
    end
`endif

endmodule

// File: tb/tb_pc_deco.sv
// tb_pc_deco: bench for pc_deco.
// The driver applies one directed vector per clock and queues the
// hand-computed outputs for that edge. An independent monitor pops the
// queue after each rising edge and compares against the DUT. Counter
// expectations are only compared when PC_DECO_STATS_EN is defined.
module tb_pc_deco;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pc_deco_if bif ();

`ifdef PC_DECO_STATS_EN
    logic [1:0] branch_cnt;
    logic [1:0] taken_cnt;
    logic [1:0] jump_cnt;
`endif

    pc_deco #(.CNT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
`ifdef PC_DECO_STATS_EN
        ,
        .branch_cnt (branch_cnt),
        .taken_cnt  (taken_cnt),
        .jump_cnt   (jump_cnt)
`endif
    );

    string      q_name[$];
    logic [1:0] q_sel[$];
    logic       q_flush[$];
    logic       q_ill[$];
    logic [1:0] q_bc[$];
    logic [1:0] q_tc[$];
    logic [1:0] q_jc[$];
    bit         q_cc[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Applies a vector at the falling edge and queues the values expected after the next rising edge.
    task automatic stepc(input string nm, input logic r, input logic st,
                         input logic [1:0] j, input logic [1:0] b, input logic e, input logic g,
                         input logic [1:0] xs, input logic xf, input logic xi,
                         input bit cc, input logic [1:0] xbc, input logic [1:0] xtc,
                         input logic [1:0] xjc);
        @(negedge clk);
        rst           = r;
        bif.stall     = st;
        bif.JMPSel    = j;
        bif.BranchSel = b;
        bif.eq        = e;
        bif.bgt       = g;
        q_name.push_back(nm);
        q_sel.push_back(xs);
        q_flush.push_back(xf);
        q_ill.push_back(xi);
        q_cc.push_back(cc);
        q_bc.push_back(xbc);
        q_tc.push_back(xtc);
        q_jc.push_back(xjc);
        @(posedge clk);
    endtask

    task automatic step(input string nm, input logic r, input logic st,
                        input logic [1:0] j, input logic [1:0] b, input logic e, input logic g,
                        input logic [1:0] xs, input logic xf, input logic xi);
        stepc(nm, r, st, j, b, e, g, xs, xf, xi, 1'b0, 2'd0, 2'd0, 2'd0);
    endtask

    // Monitor: compares whatever the driver queued for the edge that just happened.
    initial begin
        string      nm;
        logic [1:0] xs;
        logic       xf;
        logic       xi;
        logic [1:0] xbc;
        logic [1:0] xtc;
        logic [1:0] xjc;
        bit         cc;
        forever begin
            @(posedge clk);
            #1;
            if (q_sel.size() != 0) begin
                nm  = q_name.pop_front();
                xs  = q_sel.pop_front();
                xf  = q_flush.pop_front();
                xi  = q_ill.pop_front();
                cc  = q_cc.pop_front();
                xbc = q_bc.pop_front();
                xtc = q_tc.pop_front();
                xjc = q_jc.pop_front();
                chk({nm, ".sel"},   bif.NextInstrSel,       xs);
                chk({nm, ".flush"}, {1'b0, bif.flush},       {1'b0, xf});
                chk({nm, ".ill"},   {1'b0, bif.illegal_jmp}, {1'b0, xi});
`ifdef PC_DECO_STATS_EN
                if (cc) begin
                    chk({nm, ".bcnt"}, branch_cnt, xbc);
                    chk({nm, ".tcnt"}, taken_cnt,  xtc);
                    chk({nm, ".jcnt"}, jump_cnt,   xjc);
                end
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bif.stall     = 1'b0;
        bif.JMPSel    = 2'b00;
        bif.BranchSel = 2'b00;
        bif.eq        = 1'b0;
        bif.bgt       = 1'b0;

        //      name       rst st  JMP    BR     eq  bgt   sel    fl  ill
        stepc("rst0",     1, 0, 2'b01, 2'b00, 1, 1,  2'b00, 0, 0, 1, 2'd0, 2'd0, 2'd0);
        step ("rst1",     1, 0, 2'b01, 2'b00, 1, 1,  2'b00, 0, 0);
        step ("rel",      0, 0, 2'b01, 2'b00, 1, 1,  2'b10, 1, 0);

        step ("j00",      0, 0, 2'b00, 2'b00, 1, 1,  2'b00, 0, 0);
        step ("j01",      0, 0, 2'b01, 2'b00, 1, 1,  2'b10, 1, 0);
        step ("j10",      0, 0, 2'b10, 2'b00, 1, 1,  2'b11, 1, 0);

        step ("beq_t",    0, 0, 2'b00, 2'b01, 1, 1,  2'b01, 1, 0);
        step ("bgt_t",    0, 0, 2'b00, 2'b10, 1, 1,  2'b01, 1, 0);
        step ("bgt_n",    0, 0, 2'b00, 2'b10, 1, 0,  2'b00, 0, 0);
        step ("bne_n",    0, 0, 2'b00, 2'b11, 1, 0,  2'b00, 0, 0);
        step ("bne_t",    0, 0, 2'b00, 2'b11, 0, 0,  2'b01, 1, 0);
        step ("beq_n",    0, 0, 2'b00, 2'b01, 0, 1,  2'b00, 0, 0);

        step ("pri",      0, 0, 2'b10, 2'b01, 1, 1,  2'b11, 1, 0);
        step ("ill",      0, 0, 2'b11, 2'b01, 1, 1,  2'b00, 0, 1);
        step ("ill_clr",  0, 0, 2'b00, 2'b00, 0, 0,  2'b00, 0, 0);

        step ("ld",       0, 0, 2'b01, 2'b00, 0, 0,  2'b10, 1, 0);
        step ("st1",      1'b0, 1, 2'b00, 2'b00, 0, 0, 2'b10, 1, 0);
        step ("st2",      0, 1, 2'b00, 2'b00, 0, 0,  2'b10, 1, 0);
        step ("st3",      0, 1, 2'b11, 2'b11, 0, 0,  2'b10, 1, 0);
        step ("unst",     0, 0, 2'b00, 2'b00, 0, 0,  2'b00, 0, 0);
        step ("ill2",     0, 0, 2'b11, 2'b00, 0, 0,  2'b00, 0, 1);
        step ("st_ill",   0, 1, 2'b00, 2'b00, 0, 0,  2'b00, 0, 1);
        step ("unst2",    0, 0, 2'b00, 2'b00, 0, 0,  2'b00, 0, 0);

        step ("mid",      0, 0, 2'b10, 2'b00, 0, 0,  2'b11, 1, 0);
        stepc("rst_mid",  1, 1, 2'b10, 2'b00, 0, 0,  2'b00, 0, 0, 1, 2'd0, 2'd0, 2'd0);

        // Counter run with a 2-bit counter width: saturation at 3.
        stepc("tk1",      0, 0, 2'b00, 2'b01, 1, 0,  2'b01, 1, 0, 1, 2'd1, 2'd1, 2'd0);
        stepc("tk2",      0, 0, 2'b00, 2'b01, 1, 0,  2'b01, 1, 0, 1, 2'd2, 2'd2, 2'd0);
        stepc("tk3",      0, 0, 2'b00, 2'b01, 1, 0,  2'b01, 1, 0, 1, 2'd3, 2'd3, 2'd0);
        stepc("tk4",      0, 0, 2'b00, 2'b01, 1, 0,  2'b01, 1, 0, 1, 2'd3, 2'd3, 2'd0);
        stepc("tk5",      0, 0, 2'b00, 2'b01, 1, 0,  2'b01, 1, 0, 1, 2'd3, 2'd3, 2'd0);
        stepc("jmp",      0, 0, 2'b01, 2'b00, 0, 0,  2'b10, 1, 0, 1, 2'd3, 2'd3, 2'd1);
        stepc("jst",      0, 1, 2'b01, 2'b00, 0, 0,  2'b10, 1, 0, 1, 2'd3, 2'd3, 2'd1);
        stepc("jill",     0, 0, 2'b11, 2'b01, 1, 0,  2'b00, 0, 1, 1, 2'd3, 2'd3, 2'd1);
        stepc("rst_end",  1, 0, 2'b01, 2'b01, 1, 1,  2'b00, 0, 0, 1, 2'd0, 2'd0, 2'd0);
        stepc("nt",       0, 0, 2'b00, 2'b10, 1, 0,  2'b00, 0, 0, 1, 2'd1, 2'd0, 2'd0);
        stepc("jreg",     0, 0, 2'b10, 2'b11, 0, 0,  2'b11, 1, 0, 1, 2'd1, 2'd0, 2'd1);

        repeat (2) @(posedge clk);
        #2;
        total++;
        if (q_sel.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q_sel.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
